// File: rtl/display_event_scheduler_pkg.sv
// Shared types and constants for the display event scheduler.
// Arbiter/converter state encodings and background tag values.
package display_event_scheduler_pkg;

  typedef enum logic {
    S_BG,
    S_EVT
  } arb_state_t;

  typedef enum logic [1:0] {
    CV_LOAD,
    CV_SHIFT,
    CV_DONE
  } cv_state_t;

  localparam logic [3:0] BG_TAG_X = 4'h1;
  localparam logic [3:0] BG_TAG_Y = 4'h0;
  localparam int         BCD_MAX  = 999;
  localparam int         CV_BITS  = 10;

endpackage

// File: rtl/bin10_to_bcd_seq.sv
// Iterative 10-bit binary to 3-digit BCD converter (double dabble).
// One conversion: load, ten add-3/shift steps, done.
module bin10_to_bcd_seq
  import display_event_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  cv_state_t   st;
  logic [3:0]  cnt;
  logic [21:0] sr;
  logic [21:0] adj;
  logic [9:0]  sat;

  assign sat = (bin > 10'(BCD_MAX)) ? 10'(BCD_MAX) : bin;

  always_comb begin
    adj = sr;
    for (int d = 0; d < 3; d++) begin
      if (sr[10+4*d +: 4] >= 4'd5)
        adj[10+4*d +: 4] = sr[10+4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= CV_LOAD;
      cnt  <= '0;
      sr   <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        CV_LOAD: begin
          if (start) begin
            st   <= CV_SHIFT;
            sr   <= {12'd0, sat};
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        CV_SHIFT: begin
          sr  <= adj << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(CV_BITS - 1)) begin
            st   <= CV_DONE;
            bcd  <= adj[20:9];
            done <= 1'b1;
          end
        end
        CV_DONE: begin
          st   <= CV_LOAD;
          busy <= 1'b0;
        end
        default: st <= CV_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/display_event_scheduler.sv
// Owns the seven-segment bus: BCD mouse coordinate in the background,
// fixed-priority preemptive event takeover with a hold timer.
module display_event_scheduler
  import display_event_scheduler_pkg::*;
#(
  parameter int NEV         = 2,
  parameter int HOLD_CYCLES = 33554432,
  parameter int CNT_W       = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bg_sel,
  input  logic [9:0]        bg0_bin,
  input  logic [9:0]        bg1_bin,
  input  logic [NEV-1:0]    ev_pulse,
  input  logic [16*NEV-1:0] ev_nums,
  output logic [15:0]       nums,
  output logic [NEV-1:0]    ev_active,
  output logic              busy
);

  localparam int IW = (NEV > 1) ? $clog2(NEV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  arb_state_t       state;
  logic [IW-1:0]    w;
  logic [IW-1:0]    win;
  logic [NEV-1:0]   pending;
  logic [NEV-1:0]   cand;
  logic [NEV-1:0]   clr;
  logic [15:0]      val_q [NEV];
  logic [15:0]      win_val;
  logic [CNT_W-1:0] cnt;
  logic             any_cand;
  logic             pre;
  logic             grant;
  logic             restart;
  logic             release_bg;

  logic        cv_busy;
  logic        cv_done;
  logic [11:0] cv_bcd;
  logic        tag_q;
  logic [15:0] bg_nums;

  bin10_to_bcd_seq u_cv (
    .clk   (clk),
    .rst   (rst),
    .start (1'b1),
    .bin   (bg_sel ? bg0_bin : bg1_bin),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  // Tag is captured on the same edge the converter samples its input.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= 1'b0;
      bg_nums <= '0;
    end else begin
      if (!cv_busy)
        tag_q <= bg_sel;
      if (cv_done)
        bg_nums <= {tag_q ? BG_TAG_X : BG_TAG_Y, cv_bcd};
    end
  end

  always_comb begin
    cand     = pending | ev_pulse;
    any_cand = |cand;
    win      = '0;
    pre      = 1'b0;
    for (int i = NEV - 1; i >= 0; i--) begin
      if (cand[i])
        win = IW'(i);
    end
    for (int i = 0; i < NEV; i++) begin
      if (cand[i] && (IW'(i) < w))
        pre = 1'b1;
    end
    win_val = ev_pulse[win] ? ev_nums[16*win +: 16] : val_q[win];

    grant      = any_cand && ((state == S_BG) || pre ||
                 (!ev_pulse[w] && (cnt == LAST)));
    restart    = (state == S_EVT) && !pre && ev_pulse[w];
    release_bg = (state == S_EVT) && !pre && !ev_pulse[w] &&
                 (cnt == LAST) && !any_cand;

    clr = '0;
    if (grant)
      clr = NEV'(1) << win;
    else if (restart)
      clr = NEV'(1) << w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_BG;
      w         <= '0;
      cnt       <= '0;
      pending   <= '0;
      nums      <= '0;
      ev_active <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NEV; i++)
        val_q[i] <= '0;
    end else begin
      for (int i = 0; i < NEV; i++) begin
        if (ev_pulse[i])
          val_q[i] <= ev_nums[16*i +: 16];
      end
      pending <= cand & ~clr;
      unique case (1'b1)
        grant: begin
          state     <= S_EVT;
          w         <= win;
          cnt       <= '0;
          nums      <= win_val;
          ev_active <= NEV'(1) << win;
          busy      <= 1'b1;
        end
        restart: begin
          cnt  <= '0;
          nums <= ev_nums[16*w +: 16];
        end
        release_bg: begin
          state     <= S_BG;
          nums      <= bg_nums;
          ev_active <= '0;
          busy      <= 1'b0;
        end
        default: begin
          if (state == S_EVT)
            cnt <= cnt + 1'b1;
          else
            nums <= bg_nums;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_event_scheduler.sv
// Bench for display_event_scheduler: background vector table, event
// corner sequences, and randomized events against a reference model.
module tb_display_event_scheduler;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bg_sel;
  logic [9:0]  bg0_bin;
  logic [9:0]  bg1_bin;
  logic [1:0]  ev_pulse;
  logic [31:0] ev_nums;
  logic [15:0] nums;
  logic [1:0]  ev_active;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  display_event_scheduler #(
    .NEV         (2),
    .HOLD_CYCLES (H),
    .CNT_W       (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bg_sel    (bg_sel),
    .bg0_bin   (bg0_bin),
    .bg1_bin   (bg1_bin),
    .ev_pulse  (ev_pulse),
    .ev_nums   (ev_nums),
    .nums      (nums),
    .ev_active (ev_active),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] bcd_of(bit tag, int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {tag ? 4'h1 : 4'h0, 4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  typedef struct {
    bit          sel;
    int          b0;
    int          b1;
    logic [15:0] exp;
  } bg_vec_t;

  bg_vec_t bgv[6];

  // Reference model: owner index (-1 = background), elapsed hold count.
  int          m_own;
  int          m_cnt;
  bit          m_pend[2];
  logic [15:0] m_val[2];
  logic [15:0] m_bg;

  task automatic m_grant(int i);
    m_own = i;
    m_cnt = 0;
    m_pend[i] = 1'b0;
  endtask

  task automatic model_step(logic [1:0] p, logic [31:0] en);
    int win;
    win = -1;
    for (int i = 0; i < 2; i++) begin
      if (p[i]) m_val[i] = en[16*i +: 16];
      m_pend[i] = m_pend[i] | p[i];
    end
    for (int i = 1; i >= 0; i--)
      if (m_pend[i]) win = i;
    if (m_own < 0) begin
      if (win >= 0) m_grant(win);
    end else if (win >= 0 && win < m_own) begin
      m_grant(win);
    end else if (p[m_own]) begin
      m_cnt = 0;
      m_pend[m_own] = 1'b0;
    end else if (m_cnt == H - 1) begin
      if (win >= 0) m_grant(win);
      else m_own = -1;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [31:0] m_exp();
    if (m_own < 0) return {13'd0, 1'b0, 2'b00, m_bg};
    return {13'd0, 1'b1, 2'(1 << m_own), m_val[m_own]};
  endfunction

  function automatic logic [31:0] obs();
    return {13'd0, busy, ev_active, nums};
  endfunction

  task automatic pulse(logic [1:0] p, logic [31:0] en);
    ev_nums  = en;
    ev_pulse = p;
    tick();
    ev_pulse = 2'b00;
  endtask

  initial begin
    bit found;
    bit saw_busy;
    logic [1:0] p;
    logic [15:0] bg_now;

    rst = 1'b1;
    bg_sel = 1'b0;
    bg0_bin = '0;
    bg1_bin = '0;
    ev_pulse = '0;
    ev_nums = '0;
    tick(2);
    chk("reset_nums", {16'd0, nums}, 32'h0);
    chk("reset_active", {30'd0, ev_active}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;

    bgv[0] = '{1'b1, 537, 0, 16'h1537};
    bgv[1] = '{1'b0, 537, 42, 16'h0042};
    bgv[2] = '{1'b1, 1023, 0, 16'h1999};
    bgv[3] = '{1'b1, 0, 0, 16'h1000};
    bgv[4] = '{1'b0, 5, 999, 16'h0999};
    bgv[5] = '{1'b0, 5, 1000, 16'h0999};
    foreach (bgv[i]) begin
      bg_sel  = bgv[i].sel;
      bg0_bin = 10'(bgv[i].b0);
      bg1_bin = 10'(bgv[i].b1);
      tick(30);
      chk($sformatf("bg_vec%0d", i), {16'd0, nums}, {16'd0, bgv[i].exp});
    end

    bg_sel = 1'b1;
    bg0_bin = 10'd537;
    tick(30);
    bg_sel = 1'b0;
    bg1_bin = 10'd42;
    found = 1'b0;
    for (int k = 0; k < 26 && !found; k++) begin
      tick();
      if (nums == 16'h0042) found = 1'b1;
    end
    chk("bg_switch_bound", {31'd0, found}, 32'd1);
    bg_now = 16'h0042;

    // Single event holds for exactly H cycles.
    pulse(2'b10, {16'hCAFE, 16'h0000});
    for (int k = 0; k < H; k++) begin
      chk("ev1_hold", obs(), {13'd0, 1'b1, 2'b10, 16'hCAFE});
      tick();
    end
    chk("ev1_release", obs(), {13'd0, 1'b0, 2'b00, bg_now});

    // Preemption at count 3; preempted owner is dropped.
    pulse(2'b10, {16'h1234, 16'h0000});
    tick(3);
    pulse(2'b01, {16'h0000, 16'h0B0B});
    for (int k = 0; k < H; k++) begin
      chk("preempt_hold", obs(), {13'd0, 1'b1, 2'b01, 16'h0B0B});
      tick();
    end
    chk("preempt_release", obs(), {13'd0, 1'b0, 2'b00, bg_now});

    // Simultaneous requests served in index order.
    pulse(2'b11, {16'h2222, 16'h1111});
    for (int k = 0; k < H; k++) begin
      chk("simul_first", obs(), {13'd0, 1'b1, 2'b01, 16'h1111});
      tick();
    end
    for (int k = 0; k < H; k++) begin
      chk("simul_second", obs(), {13'd0, 1'b1, 2'b10, 16'h2222});
      tick();
    end
    chk("simul_release", obs(), {13'd0, 1'b0, 2'b00, bg_now});

    // Reset mid-event discards the pending request.
    pulse(2'b11, {16'h2222, 16'h1111});
    chk("rst_pre_busy", obs(), {13'd0, 1'b1, 2'b01, 16'h1111});
    rst = 1'b1;
    tick();
    chk("rst_mid", obs(), 32'h0);
    rst = 1'b0;
    saw_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy || ev_active != 2'b00) saw_busy = 1'b1;
    end
    chk("rst_no_pending", {31'd0, saw_busy}, 32'd0);

    // Randomized events over a steady background.
    bg_sel = 1'b1;
    bg0_bin = 10'($urandom_range(0, 1023));
    m_bg = bcd_of(1'b1, int'(bg0_bin));
    tick(30);
    m_own = -1;
    m_cnt = 0;
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    m_val[0] = '0;
    m_val[1] = '0;
    for (int k = 0; k < 400; k++) begin
      p[0] = ($urandom_range(0, 7) == 0);
      p[1] = ($urandom_range(0, 7) == 0);
      ev_nums = $urandom;
      ev_pulse = p;
      model_step(p, ev_nums);
      tick();
      chk($sformatf("rand%0d", k), obs(), m_exp());
    end
    ev_pulse = 2'b00;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
